// File: rtl/afc_ncntr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : afc_ncntr_pkg
// Purpose  : Shared constants for the AFC VCO frequency counter. This file
//            holds the default widths, the saturation value, the FSM state
//            encoding and the input-path latency helper.
// Config   : AFC_NCNTR_DEGLITCH_EN adds one cycle to the input-path latency.
// Revision : 1.0  initial release
// ============================================================================
package afc_ncntr_pkg;

    localparam int CNT_W_DEF       = 14;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [13:0] NCNTR_MAX = 14'h3FFF;

    // Counter FSM state encoding
    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Clock cycles from a vco_div_in rising edge to the edge pulse.
    // The count-window enable is delayed by the same amount.
    function automatic int sync_edge_latency(input int sync_stages);
`ifdef AFC_NCNTR_DEGLITCH_EN
        return sync_stages + 2;
`else
        return sync_stages + 1;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/afc_ncntr_if.sv
`default_nettype none
// ============================================================================
// Module   : afc_ncntr_if
// Purpose  : Control and result bundle between the AFC search engine (master)
//            and the VCO frequency counter (slave).
// Signals  : afc_cntr_rstn    master->slave  sync active-low counter clear
//            afc_cntr_en      master->slave  count window enable
//            afc_cntr_datasyn master->slave  1-cycle latch strobe
//            a2d_afc_ncntr    slave->master  latched count [CNT_W]
//            ncntr_valid      slave->master  1-cycle pulse, count updated
//            ncntr_ovf        slave->master  sticky saturation flag
// Revision : 1.0  initial release
// ============================================================================
interface afc_ncntr_if #(
    parameter int CNT_W = 14
);
    logic             afc_cntr_rstn;
    logic             afc_cntr_en;
    logic             afc_cntr_datasyn;
    logic [CNT_W-1:0] a2d_afc_ncntr;
    logic             ncntr_valid;
    logic             ncntr_ovf;

    modport master (
        output afc_cntr_rstn,
        output afc_cntr_en,
        output afc_cntr_datasyn,
        input  a2d_afc_ncntr,
        input  ncntr_valid,
        input  ncntr_ovf
    );

    modport slave (
        input  afc_cntr_rstn,
        input  afc_cntr_en,
        input  afc_cntr_datasyn,
        output a2d_afc_ncntr,
        output ncntr_valid,
        output ncntr_ovf
    );
endinterface
`default_nettype wire

// File: rtl/afc_ncntr_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : afc_ncntr_sync_edge
// Purpose  : Synchronizes the asynchronous divided VCO clock and produces a
//            one-cycle pulse per accepted rising edge. Its latency is
//            sync_edge_latency(SYNC_STAGES) cycles (see afc_ncntr_pkg).
// Ports    : clk      in   system clock
//            rstn     in   async active-low reset
//            i_din    in   asynchronous input (vco_div_in)
//            o_edge_p out  1-cycle rising-edge pulse
// Config   : AFC_NCNTR_DEGLITCH_EN - the synchronized level must be stable for
//            two consecutive cycles before it is accepted (1 extra cycle).
// Revision : 1.0  initial release
// ============================================================================
module afc_ncntr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic i_din,
    output logic      o_edge_p
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;   // last accepted level
    logic                   r_edge;
    logic                   w_sync_q;
    logic                   w_acc;   // level accepted this cycle

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

`ifdef AFC_NCNTR_DEGLITCH_EN
    logic r_hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= w_sync_q;
        end
    end

    // A new level is taken only once it has been seen on two consecutive
    // cycles; otherwise the previously accepted level is kept.
    assign w_acc = (w_sync_q == r_hist) ? w_sync_q : r_lvl;
`else
    assign w_acc = w_sync_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lvl  <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_lvl  <= w_acc;
            r_edge <= w_acc & ~r_lvl;
        end
    end

    assign o_edge_p = r_edge;

endmodule
`default_nettype wire

// File: rtl/afc_ncntr.sv
`default_nettype none
// ============================================================================
// Module   : afc_ncntr
// Purpose  : Digital VCO frequency counter for the AFC search engine. It
//            counts rising edges of vco_div_in inside the afc_cntr_en window
//            and latches the count on afc_cntr_datasyn.
// Ports    : clk         in   system clock
//            rstn        in   async active-low reset
//            vco_div_in  in   divided VCO clock, asynchronous to clk
//            bus         afc_ncntr_if.slave (cntr_rstn/en/datasyn in;
//                        a2d_afc_ncntr/ncntr_valid/ncntr_ovf out)
// Config   : AFC_NCNTR_DEGLITCH_EN - enables the input glitch filter, which
//            lengthens both the edge path and the enable delay by one cycle.
// Revision : 1.0  initial release
// ============================================================================
module afc_ncntr
    import afc_ncntr_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  wire logic  clk,
    input  wire logic  rstn,
    input  wire logic  vco_div_in,
    afc_ncntr_if.slave bus
);

    localparam int EN_DLY = sync_edge_latency(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX =
        (CNT_W == CNT_W_DEF) ? CNT_W'(NCNTR_MAX) : {CNT_W{1'b1}};

    logic              w_edge_p;
    logic [EN_DLY-1:0] r_en_dly;
    logic              w_en_d;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_count;
    logic              w_sat;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_ncntr;
    logic              r_valid;

    afc_ncntr_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rstn     (rstn),
        .i_din    (vco_div_in),
        .o_edge_p (w_edge_p)
    );

    // Window enable delayed to line up with the edge pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en_dly <= '0;
        end else begin
            r_en_dly <= {r_en_dly[EN_DLY-2:0], bus.afc_cntr_en};
        end
    end

    assign w_en_d = r_en_dly[EN_DLY-1];

    // Counter next value; the output latch samples this so an edge counted
    // in the strobe cycle is included in the snapshot.
    assign w_count = (r_state == ST_CNT) && w_edge_p;
    assign w_sat   = (r_cnt == CNT_MAX);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!bus.afc_cntr_rstn || (r_state == ST_CLR)) begin
            w_cnt_nxt = '0;
        end else if (w_count && !w_sat) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_CLR;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_ncntr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= 1'b0;

            if (!bus.afc_cntr_rstn) begin
                // Clear wins over window and strobe; the latched result stays.
                r_state <= ST_CLR;
                r_ovf   <= 1'b0;
            end else begin
                if (bus.afc_cntr_datasyn) begin
                    r_ncntr <= w_cnt_nxt;
                    r_valid <= 1'b1;
                end

                case (r_state)
                    ST_CLR: begin
                        r_ovf   <= 1'b0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_en_d) begin
                            r_state <= ST_CNT;
                        end
                    end
                    ST_CNT: begin
                        if (w_count && w_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (!w_en_d) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // Reopening the window keeps accumulating.
                        if (w_en_d) begin
                            r_state <= ST_CNT;
                        end
                    end
                    default: begin
                        r_state <= ST_CLR;
                    end
                endcase
            end
        end
    end

    assign bus.a2d_afc_ncntr = r_ncntr;
    assign bus.ncntr_valid   = r_valid;
    assign bus.ncntr_ovf     = r_ovf;

endmodule
`default_nettype wire
